// File: rtl/ram_sdp_be_clr.sv
// Single-clock simple dual-port RAM: byte-enabled writes, latency 1 or 2 reads,
// selectable read-during-write policy and an automatic zero-clear after reset.
module ram_sdp_be_clr #(
    parameter int DATA_W          = 32,
    parameter int DEPTH           = 64,
    parameter int ADDR_W          = $clog2(DEPTH),
    parameter int OUTREG          = 0,
    parameter int RDW_WRITE_FIRST = 1,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [DATA_W/8-1:0] ben_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o,
    output logic                ready_o
);

    localparam int NB = DATA_W / 8;
    localparam logic S_CLEAR = 1'b0;
    localparam logic S_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic                state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                wr_ok;
    logic                rd_ok;
    logic                rd_fire;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic [NB-1:0]       mem_ben;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   s1_data;
    logic                s1_valid;

    assign run     = (state == S_RUN);
    assign ready_o = run;
    assign rd_fire = run && rd_en_i;

    // Non-power-of-two depths need an explicit range check on both ports.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part
            localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
            assign wr_ok = (wr_addr_i < LIMIT);
            assign rd_ok = (rd_addr_i < LIMIT);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == LAST) begin
                state <= S_RUN;
            end
        end
    end

    // The clear engine owns the write port until it finishes.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = clr_cnt;
        mem_data = '0;
        mem_ben  = '1;
        if (!rst_i) begin
            if (!run) begin
                mem_we = 1'b1;
            end else begin
                mem_we   = wr_en_i && wr_ok;
                mem_addr = wr_addr_i;
                mem_data = wr_data_i;
                mem_ben  = ben_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NB; k++) begin
            if (mem_we && mem_ben[k]) begin
                mem[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_addr_i];
            if ((RDW_WRITE_FIRST != 0) && mem_we && (mem_addr == rd_addr_i)) begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (mem_ben[k]) begin
                        rd_word[8*k +: 8] = mem_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            logic [DATA_W-1:0] q_data;
            logic              q_valid;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_data  <= '0;
                    q_valid <= 1'b0;
                end else begin
                    q_valid <= s1_valid;
                    if (s1_valid) begin
                        q_data <= s1_data;
                    end
                end
            end

            assign rd_data_o  = q_data;
            assign rd_valid_o = q_valid;
        end else begin : g_noreg
            assign rd_data_o  = s1_data;
            assign rd_valid_o = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: two configurations share one stimulus stream and are
// compared every cycle against an array-based reference, plus directed checks.
module tb_ram_sdp_be_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [3:0]  ben = '0;
    logic [5:0]  wa  = '0;
    logic [31:0] wd  = '0;
    logic        re  = 1'b0;
    logic [5:0]  ra  = '0;

    logic [31:0] d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_ready, d1_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_sdp_be_clr #(
        .DATA_W(32), .DEPTH(64), .OUTREG(0), .RDW_WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .ben_i(ben), .wr_addr_i(wa),
        .wr_data_i(wd), .rd_en_i(re), .rd_addr_i(ra), .rd_data_o(d0_data),
        .rd_valid_o(d0_valid), .ready_o(d0_ready)
    );

    ram_sdp_be_clr #(
        .DATA_W(32), .DEPTH(48), .OUTREG(1), .RDW_WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .ben_i(ben), .wr_addr_i(wa),
        .wr_data_i(wd), .rd_en_i(re), .rd_addr_i(ra), .rd_data_o(d1_data),
        .rd_valid_o(d1_valid), .ready_o(d1_ready)
    );

    // Reference model: word arrays, remaining-clear countdown, list of results in flight.
    logic [31:0] m_mem [2][64];
    int          m_clr [2];
    bit          m_v1  [2];
    logic [31:0] m_d1  [2];
    bit          m_vo  [2];
    logic [31:0] m_do  [2];
    bit          m_known = 1'b0;

    function automatic int depth_of(input int i);
        return (i == 0) ? 64 : 48;
    endfunction
    function automatic bit outreg_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic bit wfirst_of(input int i);
        return (i == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int          d;
            bit          fire;
            logic [31:0] res;
            d    = depth_of(i);
            fire = 1'b0;
            res  = '0;
            if (rst) begin
                m_clr[i] = d;
                m_v1[i]  = 1'b0;
                m_d1[i]  = '0;
                m_vo[i]  = 1'b0;
                m_do[i]  = '0;
            end else begin
                if (m_clr[i] > 0) begin
                    m_mem[i][d - m_clr[i]] = '0;
                    m_clr[i]--;
                end else begin
                    fire = re;
                    if (int'(ra) < d) begin
                        res = m_mem[i][ra];
                        if (wfirst_of(i) && we && (wa == ra))
                            for (int k = 0; k < 4; k++)
                                if (ben[k]) res[8*k +: 8] = wd[8*k +: 8];
                    end
                    if (we && int'(wa) < d)
                        for (int k = 0; k < 4; k++)
                            if (ben[k]) m_mem[i][wa][8*k +: 8] = wd[8*k +: 8];
                end
                if (outreg_of(i)) begin
                    if (m_v1[i]) m_do[i] = m_d1[i];
                    m_vo[i] = m_v1[i];
                    if (fire) m_d1[i] = res;
                    m_v1[i] = fire;
                end else begin
                    if (fire) m_do[i] = res;
                    m_vo[i] = fire;
                end
            end
        end
        if (rst) m_known = 1'b1;
    endtask

    task automatic model_check();
        if (m_known) begin
            check("m0_valid", 32'(d0_valid), 32'(m_vo[0]));
            check("m0_data",  d0_data, m_do[0]);
            check("m0_ready", 32'(d0_ready), 32'(m_clr[0] == 0));
            check("m1_valid", 32'(d1_valid), 32'(m_vo[1]));
            check("m1_data",  d1_data, m_do[1]);
            check("m1_ready", 32'(d1_ready), 32'(m_clr[1] == 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle();
        we = 1'b0; ben = '0; wa = '0; wd = '0; re = 1'b0; ra = '0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  ben;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [5:0]  ra;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tv [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b1, 4'hF, 6'd5,  32'h11223344, 1'b0, 6'd0,  1'b0, 32'h0};
        tv[1]  = '{1'b1, 4'h5, 6'd5,  32'hAABBCCDD, 1'b0, 6'd0,  1'b0, 32'h0};
        tv[2]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd5,  1'b1, 32'h11BB33DD};
        tv[3]  = '{1'b1, 4'hF, 6'd9,  32'hDEADBEEF, 1'b1, 6'd9,  1'b1, 32'hDEADBEEF};
        tv[4]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd9,  1'b1, 32'hDEADBEEF};
        tv[5]  = '{1'b1, 4'h3, 6'd10, 32'hDEADBEEF, 1'b1, 6'd10, 1'b1, 32'h0000BEEF};
        tv[6]  = '{1'b1, 4'h0, 6'd11, 32'hFFFFFFFF, 1'b1, 6'd11, 1'b1, 32'h00000000};
        tv[7]  = '{1'b1, 4'hF, 6'd12, 32'hCAFEF00D, 1'b1, 6'd11, 1'b1, 32'h00000000};
        tv[8]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd12, 1'b1, 32'hCAFEF00D};
        tv[9]  = '{1'b1, 4'hF, 6'd63, 32'h01020304, 1'b1, 6'd63, 1'b1, 32'h01020304};
        tv[10] = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b0, 32'h0};

        // Initial reset and clear, then fill with ones and reset again.
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (64) step();
        for (int a = 0; a < 64; a++) begin
            we = 1'b1; ben = 4'hF; wa = 6'(a); wd = 32'hFFFFFFFF;
            step();
        end
        idle();
        rst = 1'b1;
        step();
        check("rst_ready0", 32'(d0_ready), 32'd0);
        check("rst_valid0", 32'(d0_valid), 32'd0);
        check("rst_data0",  d0_data, 32'd0);
        check("rst_ready1", 32'(d1_ready), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step();
            check("clr_ready0", 32'(d0_ready), 32'(k >= 64));
            check("clr_ready1", 32'(d1_ready), 32'(k >= 48));
        end
        for (int a = 0; a < 64; a++) begin
            re = 1'b1; ra = 6'(a);
            step();
            check("clr_rd_valid", 32'(d0_valid), 32'd1);
            check("clr_rd_data",  d0_data, 32'd0);
        end
        idle();
        step();

        // Table vectors, checked against the latency-1 write-first instance.
        for (int j = 0; j < 11; j++) begin
            we = tv[j].we; ben = tv[j].ben; wa = tv[j].wa; wd = tv[j].wd;
            re = tv[j].re; ra = tv[j].ra;
            step();
            check("tbl_valid", 32'(d0_valid), 32'(tv[j].ev));
            if (tv[j].ev) check("tbl_data", d0_data, tv[j].ed);
        end
        idle();

        // Read-first instance: same-address read returns the old word.
        we = 1'b1; ben = 4'hF; wa = 6'd20; wd = 32'hDEADBEEF; re = 1'b1; ra = 6'd20;
        step();
        idle();
        step();
        check("rdw_old_valid", 32'(d1_valid), 32'd1);
        check("rdw_old_data",  d1_data, 32'h0);
        re = 1'b1; ra = 6'd20;
        step();
        idle();
        step();
        check("rdw_after_data", d1_data, 32'hDEADBEEF);

        // Streaming reads through the two-stage instance.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; ben = 4'hF; wa = 6'(i); wd = 32'h01010101 * 32'(i);
            step();
        end
        idle();
        for (int c = 0; c < 11; c++) begin
            re = (c < 8); ra = 6'(c < 8 ? c : 0);
            step();
            check("strm_valid1", 32'(d1_valid), 32'(c >= 1 && c <= 8));
            if (c >= 1) check("strm_data1", d1_data, 32'h01010101 * 32'(c <= 8 ? c - 1 : 7));
            check("strm_valid0", 32'(d0_valid), 32'(c < 8));
        end
        idle();

        // Out-of-range access on the 48-word instance.
        we = 1'b1; ben = 4'hF; wa = 6'd50; wd = 32'h12345678;
        step();
        idle();
        re = 1'b1; ra = 6'd50;
        step();
        idle();
        step();
        check("oor_valid", 32'(d1_valid), 32'd1);
        check("oor_data",  d1_data, 32'h0);
        we = 1'b1; ben = 4'hF; wa = 6'd47; wd = 32'hA5A5A5A5;
        step();
        idle();
        re = 1'b1; ra = 6'd47;
        step();
        idle();
        step();
        check("last_valid", 32'(d1_valid), 32'd1);
        check("last_data",  d1_data, 32'hA5A5A5A5);

        // Reset while a read is in flight, then requests during the clear.
        re = 1'b1; ra = 6'd3;
        step();
        idle();
        rst = 1'b1;
        step();
        check("flush_valid1", 32'(d1_valid), 32'd0);
        check("flush_data1",  d1_data, 32'h0);
        check("flush_ready1", 32'(d1_ready), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            if (k <= 40) begin
                we = 1'b1; ben = 4'hF; wa = 6'd7; wd = 32'h55555555; re = 1'b1; ra = 6'd7;
            end else begin
                idle();
            end
            step();
            check("clr2_valid1", 32'(d1_valid), 32'd0);
            check("clr2_valid0", 32'(d0_valid), 32'd0);
            check("clr2_ready1", 32'(d1_ready), 32'(k >= 48));
            check("clr2_ready0", 32'(d0_ready), 32'(k >= 64));
        end
        re = 1'b1; ra = 6'd7;
        step();
        ra = 6'd3;
        step();
        check("ign_wr_valid", 32'(d1_valid), 32'd1);
        check("ign_wr_data",  d1_data, 32'h0);
        idle();
        step();
        check("clr_a3_data", d1_data, 32'h0);

        // Randomised traffic with occasional resets, compared to the model only.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            we  = $urandom_range(0, 1) == 1;
            ben = 4'($urandom_range(0, 15));
            wa  = 6'($urandom_range(0, 63));
            wd  = $urandom;
            re  = $urandom_range(0, 2) != 0;
            ra  = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
            step();
        end
        rst = 1'b0;
        idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
